// File: rtl/kernel_dispatcher_if.sv
// Signal bundle between the kernel dispatcher, the device control register and the core array.
interface kernel_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int TW        = 3
);
  logic                    start;
  logic [7:0]              thread_count;
  logic                    done;
  logic [NUM_CORES-1:0]    core_done;
  logic [NUM_CORES-1:0]    core_reset;
  logic [NUM_CORES-1:0]    core_start;
  logic [NUM_CORES*8-1:0]  core_block_id;
  logic [NUM_CORES*TW-1:0] core_thread_count;

  modport master (
    input  start, thread_count, core_done,
    output done, core_reset, core_start, core_block_id, core_thread_count
  );

  modport slave (
    output start, thread_count, core_done,
    input  done, core_reset, core_start, core_block_id, core_thread_count
  );
endinterface

// File: rtl/kernel_dispatcher.sv
// Splits a kernel launch into fixed-size blocks and hands them one per cycle to free cores,
// counting completions until the whole kernel has finished.
module kernel_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input logic               clk,
  input logic               reset,
  kernel_dispatcher_if.master bus
);
  localparam int TW    = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int SHIFT = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {FREE, RST, BUSY} slot_t;

  state_t        state, state_next;
  slot_t         slot       [NUM_CORES];
  slot_t         slot_next  [NUM_CORES];
  logic [7:0]    block_id      [NUM_CORES];
  logic [7:0]    block_id_next [NUM_CORES];
  logic [TW-1:0] blk_cnt       [NUM_CORES];
  logic [TW-1:0] blk_cnt_next  [NUM_CORES];

  logic [7:0] tc_q, tc_next;
  logic [8:0] total, total_next;
  logic [8:0] dispatched, dispatched_next;
  logic [8:0] completed, completed_next;
  logic [8:0] launch_total;
  logic [7:0] eff_tc;
  logic [8:0] eff_total, eff_disp;
  logic [8:0] n_done;
  logic       can_dispatch, found;

  assign launch_total = (9'(bus.thread_count) + 9'(THREADS_PER_BLOCK - 1)) >> SHIFT;

  always_comb begin
    state_next      = state;
    tc_next         = tc_q;
    total_next      = total;
    dispatched_next = dispatched;
    completed_next  = completed;
    eff_tc          = tc_q;
    eff_total       = total;
    eff_disp        = dispatched;
    can_dispatch    = 1'b0;
    found           = 1'b0;
    n_done          = '0;

    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      slot_next[i]     = slot[i];
      block_id_next[i] = block_id[i];
      blk_cnt_next[i]  = blk_cnt[i];
      case (slot[i])
        RST:  slot_next[i] = BUSY;
        BUSY: if (bus.core_done[i]) begin
          slot_next[i] = FREE;
          n_done       = n_done + 9'd1;
        end
        default: ;
      endcase
    end

    case (state)
      IDLE: if (bus.start) begin
        // Block 0 is dispatched on the launch edge itself, straight from the live inputs.
        tc_next         = bus.thread_count;
        total_next      = launch_total;
        dispatched_next = '0;
        completed_next  = '0;
        eff_tc          = bus.thread_count;
        eff_total       = launch_total;
        eff_disp        = '0;
        can_dispatch    = 1'b1;
        state_next      = RUN;
      end
      RUN: begin
        completed_next = completed + n_done;
        if (completed_next == total) state_next = DONE;
        can_dispatch = 1'b1;
      end
      DONE: if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (can_dispatch && (eff_disp < eff_total)) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!found && slot[i] == FREE) begin
          found            = 1'b1;
          slot_next[i]     = RST;
          block_id_next[i] = eff_disp[7:0];
          blk_cnt_next[i]  = (eff_disp == eff_total - 9'd1)
                             ? TW'(9'(eff_tc) - ((eff_total - 9'd1) << SHIFT))
                             : TW'(THREADS_PER_BLOCK);
          dispatched_next  = eff_disp + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tc_q       <= '0;
      total      <= '0;
      dispatched <= '0;
      completed  <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        slot[i]     <= FREE;
        block_id[i] <= '0;
        blk_cnt[i]  <= '0;
      end
    end else begin
      state      <= state_next;
      tc_q       <= tc_next;
      total      <= total_next;
      dispatched <= dispatched_next;
      completed  <= completed_next;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        slot[i]     <= slot_next[i];
        block_id[i] <= block_id_next[i];
        blk_cnt[i]  <= blk_cnt_next[i];
      end
    end
  end

  always_comb begin
    bus.core_reset        = '0;
    bus.core_start        = '0;
    bus.core_block_id     = '0;
    bus.core_thread_count = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      bus.core_reset[i]                  = (slot[i] == RST);
      bus.core_start[i]                  = (slot[i] == BUSY);
      bus.core_block_id[8*i +: 8]        = block_id[i];
      bus.core_thread_count[TW*i +: TW]  = blk_cnt[i];
    end
  end

  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_kernel_dispatcher.sv
// Randomized bench for kernel_dispatcher against a block-queue reference model.
module tb_kernel_dispatcher;
  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TW  = $clog2(TPB) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kernel_dispatcher_if #(.NUM_CORES(NC), .TW(TW)) bus ();
  kernel_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 finished; cores hold 0 free, 1 reset, 2 busy.
  int ph;
  int tcl, total, finished, pulses;
  int pending[$];
  int m_kind[NC];
  int m_id[NC];
  bit chk_pulses;
  int kernels;
  bit did_reset;
  int directed[4] = '{10, 0, 8, 255};

  function automatic int blk_threads(input int tc, input int id);
    int left;
    left = tc - id * TPB;
    return (left >= TPB) ? TPB : left;
  endfunction

  function automatic int pick_tc();
    int r;
    r = int'($urandom % 8);
    if (r == 0) return 0;
    if (r == 1) return 255;
    if (r == 2) return int'($urandom_range(1, 9));
    return int'($urandom % 256);
  endfunction

  task automatic model_reset();
    ph = 0;
    pending.delete();
    chk_pulses = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_kind[i] = 0;
      m_id[i]   = 0;
    end
  endtask

  task automatic model_step(input bit st, input int tc, input logic [NC-1:0] cd);
    int nk[NC];
    int idx;
    bit go;
    go = 1'b0;
    for (int i = 0; i < NC; i++) begin
      nk[i] = m_kind[i];
      if (m_kind[i] == 1) nk[i] = 2;
      else if (m_kind[i] == 2 && cd[i]) begin
        nk[i] = 0;
        if (ph == 1) finished++;
      end
    end
    case (ph)
      0: if (st) begin
        tcl = tc;
        total = (tc + TPB - 1) / TPB;
        pending.delete();
        for (int b = 0; b < total; b++) pending.push_back(b);
        finished = 0;
        pulses = 0;
        ph = 1;
        go = 1'b1;
        kernels++;
      end
      1: begin
        if (finished == total) begin
          ph = 2;
          chk_pulses = 1'b1;
        end
        go = 1'b1;
      end
      default: if (!st) ph = 0;
    endcase
    if (go && pending.size() > 0) begin
      idx = -1;
      for (int i = 0; i < NC; i++) if (idx < 0 && m_kind[i] == 0) idx = i;
      if (idx >= 0) begin
        nk[idx]   = 1;
        m_id[idx] = pending.pop_front();
      end
    end
    for (int i = 0; i < NC; i++) m_kind[i] = nk[i];
  endtask

  task automatic check_outputs();
    logic [NC-1:0] exp_rst, exp_run;
    exp_rst = '0;
    exp_run = '0;
    for (int i = 0; i < NC; i++) begin
      exp_rst[i] = (m_kind[i] == 1);
      exp_run[i] = (m_kind[i] == 2);
    end
    check("core_reset", int'(bus.core_reset), int'(exp_rst));
    check("core_start", int'(bus.core_start), int'(exp_run));
    check("done", int'(bus.done), (ph == 2) ? 1 : 0);
    for (int i = 0; i < NC; i++) begin
      if (m_kind[i] != 0) begin
        check($sformatf("block_id[%0d]", i), int'(bus.core_block_id[8*i +: 8]), m_id[i]);
        check($sformatf("thread_count[%0d]", i), int'(bus.core_thread_count[TW*i +: TW]),
              blk_threads(tcl, m_id[i]));
      end
    end
    pulses += $countones(bus.core_reset);
    if (chk_pulses) begin
      check("reset_pulses", pulses, total);
      chk_pulses = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_reset"}, int'(bus.core_reset), 0);
    check({tag, "_core_start"}, int'(bus.core_start), 0);
    check({tag, "_block_id"}, int'(bus.core_block_id), 0);
    check({tag, "_thread_count"}, int'(bus.core_thread_count), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    bit st;
    int tc;
    logic [NC-1:0] cd;

    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.thread_count = '0;
    bus.core_done    = '0;
    kernels          = 0;
    did_reset        = 1'b0;
    total            = 0;
    tcl              = 0;
    finished         = 0;
    pulses           = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all_zero("por");
    reset = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!did_reset && kernels >= 5 && ph == 1 && pending.size() <= total - 2) begin
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        bus.start     = 1'b0;
        bus.core_done = '0;
        repeat (2) @(negedge clk);
        check_all_zero("held_rst");
        reset     = 1'b1;
        did_reset = 1'b1;
      end

      @(negedge clk);
      check_outputs();

      case (ph)
        0: begin
          if (kernels < 4) begin
            st = 1'b1;
            tc = directed[kernels];
          end else begin
            st = ($urandom % 2) == 0;
            tc = pick_tc();
          end
        end
        1: begin
          st = ($urandom % 2) == 0;
          tc = int'($urandom % 256);
        end
        default: begin
          st = ($urandom % 3) == 0;
          tc = int'($urandom % 256);
        end
      endcase
      for (int i = 0; i < NC; i++) cd[i] = ($urandom % 3) == 0;

      bus.start        = st;
      bus.thread_count = 8'(tc);
      bus.core_done    = cd;
      model_step(st, tc, cd);
    end

    check("reset_exercised", int'(did_reset), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kernel_dispatcher.md
# kernel_dispatcher

Consumes the kernel thread count held in the device control register and splits the launch into fixed-size blocks, assigning them one at a time to free compute cores. Sits between the device control register and the core array. Tracks per-core occupancy and completions, and raises `done` once every block of the kernel has finished.

## Interface

Parameters:
- `NUM_CORES`, 2: number of cores served.
- `THREADS_PER_BLOCK`, 4: threads per block; must be a power of two, 1 to 128.

Ports (TW = $clog2(THREADS_PER_BLOCK)+1):
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: kernel launch request, level-sensitive.
- `thread_count` in 8: total threads for the kernel, taken from the DCR.
- `core_done` in NUM_CORES: per-core block-finished flag, level-sensitive.
- `core_reset` out NUM_CORES: per-core one-cycle reset pulse issued before each block.
- `core_start` out NUM_CORES: per-core run request, held high while a block executes.
- `core_block_id` out NUM_CORES*8: per-core block index; core i uses bits [8i+7:8i].
- `core_thread_count` out NUM_CORES*TW: number of active threads in the assigned block.
- `done` out 1: kernel complete.

## Operation

- Global FSM states: IDLE, RUN, DONE.
- IDLE:
  - When `start`=1, latch `thread_count`.
  - Compute total_blocks = (thread_count + THREADS_PER_BLOCK - 1) / THREADS_PER_BLOCK, using 9-bit arithmetic with no overflow.
  - Clear the dispatched and completed counters, then go to RUN.
- Per-core slot FSM states: FREE, RST, BUSY.
- RUN, dispatch:
  - At most one block is dispatched per cycle.
  - It goes to the lowest-index FREE core, and only while dispatched < total_blocks.
  - That slot moves to RST with block_id = dispatched; dispatched is then incremented.
- RUN, thread count per block:
  - Normal block: core_thread_count = THREADS_PER_BLOCK.
  - Last block: core_thread_count = thread_count − (total_blocks−1)*THREADS_PER_BLOCK.
- Slot outputs:
  - RST: `core_reset`=1 for exactly one cycle, then the slot moves to BUSY.
  - BUSY: `core_start`=1.
  - `core_block_id` and `core_thread_count` stay stable from RST through BUSY.
- Completion:
  - `core_done`=1 in BUSY moves the slot to FREE with `core_start`=0.
  - completed is incremented by the number of such cores in that cycle, so simultaneous completions are all counted.
  - `core_done` is ignored in FREE and RST.
- RUN goes to DONE when completed == total_blocks. For total_blocks=0 this happens on the first RUN cycle, with no core activity.
- DONE:
  - `done`=1.
  - Stay while `start`=1; `start`=0 returns the FSM to IDLE with `done`=0.
- `start` falling during RUN is ignored; the kernel runs to completion.
- `thread_count` changes after the latch are ignored.
- A core freed in cycle n can be re-dispatched in cycle n+1.
- Reset (`reset`=0, at any time including mid-run), applied immediately and asynchronously:
  - All outputs 0.
  - All slots FREE.
  - FSM in IDLE.
  - Counters 0.

## Timing

- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: RUN.
  - Core 0 RST (`core_reset`[0]=1, block 0).
- Cycle 2: core 0 BUSY.
  - Core 1 RST with block 1, if it exists.
- Cycle k: core_done[i] sampled in BUSY.
- Cycle k+1: `core_start`[i]=0.
- The cycle after the last completion is counted: `done`=1.
- thread_count=0: `done`=1 in cycle 2.

## Test plan

- Scenario 1, partial last block:
  - Stimulus: NUM_CORES=2, TPB=4, thread_count=10, start=1; each core asserts done 3 cycles after start.
  - Response: blocks 0/1/2 with counts 4/4/2; block 2 goes to the first freed core; `done` rises once, 1 cycle after the third completion.
- Scenario 2, zero threads:
  - Stimulus: thread_count=0, start=1.
  - Response: no `core_reset`/`core_start` pulses; `done`=1 in cycle 2; start=0 gives done=0 the next cycle.
- Scenario 3, simultaneous completions:
  - Stimulus: thread_count=8, both cores assert done in the same cycle.
  - Response: completed reaches 2; `done`=1 the next cycle.
- Scenario 4, maximum count:
  - Stimulus: thread_count=255, TPB=4.
  - Response: 64 blocks, ids 0..63; last block count 3; exactly 64 `core_reset` pulses in total.
- Scenario 5, reset mid-run:
  - Stimulus: reset=0 mid-run.
  - Response: all outputs 0 without waiting for a clock edge; a relaunch after release restarts at block 0.
- Scenario 6, inputs changing mid-run:
  - Stimulus: thread_count changed and start dropped mid-run.
  - Response: the original count completes; `done` pulses for 1 cycle, then IDLE.
